// File: rtl/router_input_buffer.sv
// rtl/router_input_buffer.sv - per-port NoC router input FIFO with packet framing and arbiter request
module router_input_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] flit_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              grant,
  output logic              req,
  output logic [2:0]        flit_id,
  output logic [11:0]       length,
  output logic [DATA_W-1:0] flit_out,
  output logic              valid_out,
  output logic [AW:0]       count,
  output logic              err
);

  typedef enum logic {
    IDLE,
    PKT
  } state_t;

  localparam logic [2:0]  T_HEAD   = 3'b001;
  localparam logic [2:0]  T_BODY   = 3'b010;
  localparam logic [2:0]  T_TAIL   = 3'b100;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count_q;
  state_t            state;
  logic [11:0]       len_q;
  logic              err_q;

  logic              empty;
  logic              full;
  logic [DATA_W-1:0] head;
  logic [2:0]        head_type;
  logic              is_head;
  logic              is_tail;
  logic              is_valid;
  logic              req_c;
  logic              drop;
  logic              pop;
  logic              push;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign head      = mem[rd_ptr];
  assign head_type = head[DATA_W-1:DATA_W-3];
  assign is_head   = (head_type == T_HEAD);
  assign is_tail   = (head_type == T_TAIL);
  assign is_valid  = is_head || is_tail || (head_type == T_BODY);

  // Framing decision on the head flit: request the arbiter or discard it
  always_comb begin
    req_c = 1'b0;
    drop  = 1'b0;
    if (!rst && !empty) begin
      case (state)
        IDLE: begin
          // Outside a packet only a HEAD can start one; anything else is garbage
          req_c = is_head;
          drop  = !is_head;
        end
        PKT: begin
          // Inside a packet keep requesting; invalid codes are discarded on the spot
          req_c = 1'b1;
          drop  = !is_valid;
        end
        default: begin
          req_c = 1'b0;
          drop  = 1'b0;
        end
      endcase
    end
  end

  // Drops do not need the crossbar, so they pop without a grant
  assign pop       = !rst && !empty && ((grant && req_c) || drop);
  assign ready_out = !rst && !full;
  assign push      = valid_in && ready_out;

  assign req       = req_c;
  assign valid_out = pop && !drop;
  assign flit_id   = (!rst && !empty) ? head_type : 3'b000;
  assign flit_out  = head;
  // Header length is presented live so the arbiter timer can latch it before the pop
  assign length    = (!empty && is_head) ? head[11:0] : len_q;
  assign count     = count_q;
  assign err       = err_q;

  // Flit storage; contents need no reset because count gates their visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= flit_in;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Packet state, latched header length and sticky framing error
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (pop && !drop) begin
        if (is_head) begin
          state <= PKT;
          len_q <= head[11:0];
        end else if (is_tail) begin
          state <= IDLE;
        end
      end
      // A second HEAD before the TAIL is accepted as a new packet but flagged
      if (drop || (state == PKT && !empty && is_head)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_router_input_buffer.sv
// tb/tb_router_input_buffer.sv - self-checking bench for router_input_buffer
module tb_router_input_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] flit_in;
  logic        valid_in;
  logic        ready_out;
  logic        grant;
  logic        req;
  logic [2:0]  flit_id;
  logic [11:0] length;
  logic [31:0] flit_out;
  logic        valid_out;
  logic [3:0]  count;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        v;
    logic [31:0] f;
    logic        g;
    logic        e_ready;
    logic        e_req;
    logic [2:0]  e_id;
    logic [11:0] e_len;
    logic        e_vo;
    logic [3:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t tbl[10];

  router_input_buffer #(.DATA_W(32), .DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .valid_in(valid_in), .ready_out(ready_out),
    .grant(grant), .req(req), .flit_id(flit_id), .length(length), .flit_out(flit_out),
    .valid_out(valid_out), .count(count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [2:0] t, input logic [16:0] tag, input logic [11:0] len);
    return {t, tag, len};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs, let combinational outputs settle, then run the scoreboard
  task automatic drive(input logic v, input logic [31:0] f, input logic g, input logic fwd);
    valid_in = v;
    flit_in  = f;
    grant    = g;
    #1;
    if (v && fwd && ready_out) exp_q.push_back(f);
    if (valid_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h expected no output", flit_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (flit_out !== e) begin
          errors++;
          $display("FAIL sb_flit: got %h expected %h", flit_out, e);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic g);
    rst = 1'b1;
    drive(1'b0, 32'h0, g, 1'b0);
    chk("rst_ready", ready_out, 0);
    chk("rst_req", req, 0);
    chk("rst_flit_id", flit_id, 0);
    chk("rst_valid_out", valid_out, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] h5, b1, b2, t1, bx;
  logic [31:0] p1[8];
  logic [31:0] p2[8];

  initial begin
    rst = 1'b1; valid_in = 1'b0; flit_in = '0; grant = 1'b0;
    h5 = mk(3'b001, 17'h0, 12'h005);
    b1 = mk(3'b010, 17'h11, 12'h111);
    b2 = mk(3'b010, 17'h22, 12'h222);
    t1 = mk(3'b100, 17'h33, 12'h333);
    bx = mk(3'b010, 17'h1dead, 12'hbad);

    //            v     flit  g     rdy   req   id      len      vo    cnt   err
    tbl[0] = '{1'b1, h5, 1'b0, 1'b1, 1'b0, 3'b000, 12'h000, 1'b0, 4'd0, 1'b0};
    tbl[1] = '{1'b1, b1, 1'b0, 1'b1, 1'b1, 3'b001, 12'h005, 1'b0, 4'd1, 1'b0};
    tbl[2] = '{1'b1, b2, 1'b0, 1'b1, 1'b1, 3'b001, 12'h005, 1'b0, 4'd2, 1'b0};
    tbl[3] = '{1'b1, t1, 1'b0, 1'b1, 1'b1, 3'b001, 12'h005, 1'b0, 4'd3, 1'b0};
    tbl[4] = '{1'b0, '0, 1'b0, 1'b1, 1'b1, 3'b001, 12'h005, 1'b0, 4'd4, 1'b0};
    tbl[5] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, 3'b001, 12'h005, 1'b1, 4'd4, 1'b0};
    tbl[6] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, 3'b010, 12'h005, 1'b1, 4'd3, 1'b0};
    tbl[7] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, 3'b010, 12'h005, 1'b1, 4'd2, 1'b0};
    tbl[8] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, 3'b100, 12'h005, 1'b1, 4'd1, 1'b0};
    tbl[9] = '{1'b0, '0, 1'b1, 1'b1, 1'b0, 3'b000, 12'h005, 1'b0, 4'd0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      p1[i] = mk((i == 0) ? 3'b001 : ((i == 7) ? 3'b100 : 3'b010), 17'(16'h100 + i), 12'(8));
      p2[i] = mk((i == 0) ? 3'b001 : ((i == 7) ? 3'b100 : 3'b010), 17'(16'h200 + i), 12'(7));
    end

    // Test 1: table-driven HEAD/BODY/BODY/TAIL
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].f, tbl[i].g, 1'b1);
      chk($sformatf("t1_ready[%0d]", i), ready_out, tbl[i].e_ready);
      chk($sformatf("t1_req[%0d]", i), req, tbl[i].e_req);
      chk($sformatf("t1_id[%0d]", i), flit_id, tbl[i].e_id);
      chk($sformatf("t1_len[%0d]", i), length, tbl[i].e_len);
      chk($sformatf("t1_vo[%0d]", i), valid_out, tbl[i].e_vo);
      chk($sformatf("t1_cnt[%0d]", i), count, tbl[i].e_cnt);
      chk($sformatf("t1_err[%0d]", i), err, tbl[i].e_err);
      tick();
    end
    chk("t1_sb_empty", exp_q.size(), 0);

    // Test 2: fill to full, reject extra, then stream through at full rate
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, p1[i], 1'b0, 1'b1);
      chk($sformatf("t2_fill_cnt[%0d]", i), count, i);
      tick();
    end
    drive(1'b1, bx, 1'b0, 1'b1);
    chk("t2_full_cnt", count, 8);
    chk("t2_full_ready", ready_out, 0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t2_no_ninth", count, 8);
    tick();
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, p2[(k == 0) ? 0 : k - 1], 1'b1, 1'b1);
      chk($sformatf("t2_stream_cnt[%0d]", k), count, (k == 0) ? 8 : 7);
      chk($sformatf("t2_stream_ready[%0d]", k), ready_out, (k == 0) ? 0 : 1);
      chk($sformatf("t2_stream_vo[%0d]", k), valid_out, 1);
      tick();
    end
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk($sformatf("t2_drain_vo[%0d]", k), valid_out, 1);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t2_drained", count, 0);
    chk("t2_sb_empty", exp_q.size(), 0);
    chk("t2_err", err, 0);
    tick();

    // Test 3: BODY while idle is dropped without a request
    do_reset(1'b0);
    drive(1'b1, b1, 1'b0, 1'b0);
    chk("t3_req_push", req, 0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t3_cnt_drop", count, 1);
    chk("t3_req_drop", req, 0);
    chk("t3_vo_drop", valid_out, 0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t3_cnt_after", count, 0);
    chk("t3_err", err, 1);
    chk("t3_req_after", req, 0);
    tick();

    // Test 4: HEAD, BODY, HEAD(len=3), TAIL with grant held
    do_reset(1'b0);
    drive(1'b1, mk(3'b001, 17'h41, 12'h009), 1'b1, 1'b1);
    chk("t4_vo0", valid_out, 0);
    tick();
    drive(1'b1, mk(3'b010, 17'h42, 12'h042), 1'b1, 1'b1);
    chk("t4_len_h1", length, 12'h009);
    chk("t4_vo1", valid_out, 1);
    tick();
    drive(1'b1, mk(3'b001, 17'h43, 12'h003), 1'b1, 1'b1);
    chk("t4_vo2", valid_out, 1);
    chk("t4_err_before", err, 0);
    tick();
    drive(1'b1, mk(3'b100, 17'h44, 12'h044), 1'b1, 1'b1);
    chk("t4_len_h2", length, 12'h003);
    chk("t4_vo3", valid_out, 1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t4_err", err, 1);
    chk("t4_len_reg", length, 12'h003);
    chk("t4_vo4", valid_out, 1);
    tick();
    drive(1'b1, b2, 1'b0, 1'b0);
    chk("t4_req_end", req, 0);
    chk("t4_cnt_end", count, 0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t4_idle_req", req, 0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t4_idle_dropped", count, 0);
    chk("t4_sb_empty", exp_q.size(), 0);
    tick();

    // Test 5: grant withdrawn mid-packet, then regranted
    do_reset(1'b0);
    drive(1'b1, h5, 1'b0, 1'b1); tick();
    drive(1'b1, b1, 1'b0, 1'b1); tick();
    drive(1'b1, b2, 1'b0, 1'b1); tick();
    drive(1'b1, t1, 1'b0, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t5_vo_head", valid_out, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      chk($sformatf("t5_hold_req[%0d]", k), req, 1);
      chk($sformatf("t5_hold_cnt[%0d]", k), count, 3);
      chk($sformatf("t5_hold_vo[%0d]", k), valid_out, 0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t5_resume_vo", valid_out, 1);
    chk("t5_resume_id", flit_id, 3'b010);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t5_cnt_end", count, 0);
    chk("t5_sb_empty", exp_q.size(), 0);
    tick();

    // Test 6: reset with five flits buffered and err set
    do_reset(1'b0);
    drive(1'b1, b1, 1'b0, 1'b0); tick();
    drive(1'b1, h5, 1'b0, 1'b1); tick();
    drive(1'b1, b1, 1'b0, 1'b1); tick();
    drive(1'b1, b2, 1'b0, 1'b1); tick();
    drive(1'b1, b2, 1'b0, 1'b1); tick();
    drive(1'b1, t1, 1'b0, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t6_cnt_pre", count, 5);
    chk("t6_err_pre", err, 1);
    tick();
    do_reset(1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t6_cnt", count, 0);
    chk("t6_req", req, 0);
    chk("t6_id", flit_id, 0);
    chk("t6_err", err, 0);
    chk("t6_ready", ready_out, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
